// File: rtl/cordic_result_sink.sv
// rtl/cordic_result_sink.sv - result collector and credit source for the fixed-latency CORDIC pipeline
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   issue_valid         issuer drove a real sample into the pipeline this cycle
//   issue_ok            credit: issuer may assert issue_valid this cycle
//   degree_out, x_out,
//   y_out, sector_out,
//   arctan_en_out       pipeline output word, sampled when the delayed tag says it is real
//   m_valid, m_ready    first-word fall-through result handshake
//   m_degree, m_x, m_y,
//   m_sector,
//   m_arctan_en         head-of-FIFO result, zero while m_valid is low
//   fifo_count          number of buffered results
//   err                 sticky: issue without credit, or capture dropped on a full FIFO

module cordic_result_sink #(
  parameter int DATA_WIDTH        = 16,
  parameter int SECTOR_FLAG_WIDTH = 2,
  parameter int PIPE_LATENCY      = 8,
  parameter int FIFO_DEPTH        = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             issue_valid,
  output logic                             issue_ok,
  input  logic [DATA_WIDTH-1:0]            degree_out,
  input  logic [DATA_WIDTH-1:0]            x_out,
  input  logic [DATA_WIDTH-1:0]            y_out,
  input  logic [SECTOR_FLAG_WIDTH-1:0]     sector_out,
  input  logic                             arctan_en_out,
  output logic                             m_valid,
  input  logic                             m_ready,
  output logic [DATA_WIDTH-1:0]            m_degree,
  output logic [DATA_WIDTH-1:0]            m_x,
  output logic [DATA_WIDTH-1:0]            m_y,
  output logic [SECTOR_FLAG_WIDTH-1:0]     m_sector,
  output logic                             m_arctan_en,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count,
  output logic                             err
);

  localparam int ENTRY_W = 3 * DATA_WIDTH + SECTOR_FLAG_WIDTH + 1;
  localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int INF_W   = $clog2(PIPE_LATENCY + 1);
  localparam logic [31:0] DEPTH_U = FIFO_DEPTH;

  // Tag shift register mirrors the pipeline: a one at position i means the
  // sample currently in pipeline stage i is real.
  logic [PIPE_LATENCY-1:0] tag;
  logic [INF_W-1:0]        inflight;
  logic                    cap;

  logic [ENTRY_W-1:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic [ENTRY_W-1:0]      entry_in;
  logic [ENTRY_W-1:0]      entry_head;

  logic full;
  logic pop;
  logic push;
  logic drop;

  assign cap      = tag[PIPE_LATENCY-1];
  assign full     = (fifo_count == CNT_W'(FIFO_DEPTH));
  assign m_valid  = (fifo_count != '0);
  assign pop      = m_valid && m_ready;
  // A full FIFO still accepts a capture when the head leaves in the same cycle.
  assign push     = cap && (!full || pop);
  assign drop     = cap && full && !pop;

  // Credit counts slots already promised to in-flight samples, so a result
  // always finds room when it emerges. Built from registers only, so there is
  // no combinational path from m_ready.
  assign issue_ok = (32'(fifo_count) + 32'(inflight)) < DEPTH_U;

  assign entry_in   = {degree_out, x_out, y_out, sector_out, arctan_en_out};
  assign entry_head = m_valid ? mem[rd_ptr] : '0;
  assign {m_degree, m_x, m_y, m_sector, m_arctan_en} = entry_head;

  // Tag pipeline. An issue without credit is still tagged so its result slot
  // is accounted for; the overflow shows up later as a drop.
  always_ff @(posedge clk) begin
    if (reset) begin
      tag <= '0;
    end else begin
      tag[0] <= issue_valid;
      for (int i = 1; i < PIPE_LATENCY; i++) begin
        tag[i] <= tag[i-1];
      end
    end
  end

  // Running popcount of the tag register.
  always_ff @(posedge clk) begin
    if (reset) begin
      inflight <= '0;
    end else begin
      case ({issue_valid, cap})
        2'b10:   inflight <= inflight + INF_W'(1);
        2'b01:   inflight <= inflight - INF_W'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  // Result storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= entry_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err <= 1'b0;
    end else if ((issue_valid && !issue_ok) || drop) begin
      err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cordic_result_sink.sv
// tb/tb_cordic_result_sink.sv - self-checking bench for cordic_result_sink

module tb_cordic_result_sink;

  localparam int DW = 16;
  localparam int SW = 2;
  localparam int PL = 8;
  localparam int FD = 16;
  localparam int CW = $clog2(FD + 1);

  typedef struct packed {
    logic [DW-1:0] deg;
    logic [DW-1:0] x;
    logic [DW-1:0] y;
    logic [SW-1:0] sec;
    logic          arc;
  } entry_t;

  typedef struct {
    logic       iv;
    logic       mr;
    logic       ev;
    logic [4:0] ecnt;
    logic       eok;
    logic       eerr;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          issue_valid = 1'b0;
  logic          m_ready = 1'b0;
  entry_t        pipe_in = '0;
  entry_t        pipe [PL];
  logic          issue_ok;
  logic          m_valid;
  logic [DW-1:0] m_degree, m_x, m_y;
  logic [SW-1:0] m_sector;
  logic          m_arctan_en;
  logic [CW-1:0] fifo_count;
  logic          err;
  entry_t        got;

  int checks = 0;
  int errors = 0;
  entry_t sbq[$];

  always #5 clk = ~clk;

  // Behavioural fixed-latency pipeline: input sampled at an edge appears on
  // the output PL edges later.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < PL; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= pipe_in;
      for (int i = 1; i < PL; i++) pipe[i] <= pipe[i-1];
    end
  end

  cordic_result_sink #(
    .DATA_WIDTH(DW), .SECTOR_FLAG_WIDTH(SW), .PIPE_LATENCY(PL), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_ok(issue_ok),
    .degree_out(pipe[PL-1].deg), .x_out(pipe[PL-1].x), .y_out(pipe[PL-1].y),
    .sector_out(pipe[PL-1].sec), .arctan_en_out(pipe[PL-1].arc),
    .m_valid(m_valid), .m_ready(m_ready), .m_degree(m_degree), .m_x(m_x), .m_y(m_y),
    .m_sector(m_sector), .m_arctan_en(m_arctan_en), .fifo_count(fifo_count), .err(err)
  );

  assign got = {m_degree, m_x, m_y, m_sector, m_arctan_en};

  function automatic entry_t mk(input logic [DW-1:0] d);
    entry_t e;
    e.deg = d;
    e.x   = d ^ 16'h5a5a;
    e.y   = d + 16'h0100;
    e.sec = d[5:4];
    e.arc = d[4];
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one sample into the pipeline; kept=0 marks a sample expected to be dropped.
  task automatic issue(input logic [DW-1:0] d, input bit kept);
    issue_valid = 1'b1;
    pipe_in     = mk(d);
    if (kept) sbq.push_back(mk(d));
  endtask

  // Scoreboard: every accepted pop must match the oldest expected result.
  always @(negedge clk) begin : mon
    entry_t e;
    if (!reset && m_valid && m_ready) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected: got %0h expected no result", got);
      end else begin
        e = sbq.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL pop_data: got %0h expected %0h", got, e);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [22];
    int   acc;
    int   budget;

    for (int c = 0; c < 22; c++) begin
      tbl[c].iv   = (c == 10);
      tbl[c].mr   = 1'b1;
      tbl[c].ev   = (c == 19);
      tbl[c].ecnt = (c == 19) ? 5'd1 : 5'd0;
      tbl[c].eok  = 1'b1;
      tbl[c].eerr = 1'b0;
    end

    reset = 1'b1;
    step(); step(); step();
    reset = 1'b0;

    // Single issue: reset state on row 0, PL+1 latency, empty push+pop.
    for (int c = 0; c < 22; c++) begin
      issue_valid = 1'b0;
      if (tbl[c].iv) issue(16'h0010, 1'b1);
      m_ready = tbl[c].mr;
      chk($sformatf("t1_valid_c%0d", c), 64'(m_valid), 64'(tbl[c].ev));
      chk($sformatf("t1_count_c%0d", c), 64'(fifo_count), 64'(tbl[c].ecnt));
      chk($sformatf("t1_ok_c%0d", c), 64'(issue_ok), 64'(tbl[c].eok));
      chk($sformatf("t1_err_c%0d", c), 64'(err), 64'(tbl[c].eerr));
      if (!m_valid) chk($sformatf("t1_zero_c%0d", c), 64'(got), 64'd0);
      step();
    end
    issue_valid = 1'b0;

    // Back-to-back issues with a ready sink: continuous output stream.
    for (int c = 0; c < 50; c++) begin
      issue_valid = 1'b0;
      if (c < 40) issue(16'h0100 + 16'(c * 16), 1'b1);
      m_ready = 1'b1;
      chk("t2_ok", 64'(issue_ok), 64'd1);
      if (c >= 9 && c < 49) chk($sformatf("t2_valid_c%0d", c), 64'(m_valid), 64'd1);
      step();
    end
    issue_valid = 1'b0;
    chk("t2_count", 64'(fifo_count), 64'd0);
    chk("t2_err", 64'(err), 64'd0);

    // Stalled sink: credit limits accepted issues to FIFO depth.
    m_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 40; c++) begin
      issue_valid = 1'b0;
      if (issue_ok) begin
        issue(16'h1000 + 16'(acc * 16), 1'b1);
        acc++;
      end
      step();
    end
    issue_valid = 1'b0;
    chk("t3_accepted", 64'(acc), 64'd16);
    chk("t3_count", 64'(fifo_count), 64'd16);
    chk("t3_ok_low", 64'(issue_ok), 64'd0);
    chk("t3_err", 64'(err), 64'd0);

    // One pop returns one credit; the first-issued sample leaves first.
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    chk("t4_ok_back", 64'(issue_ok), 64'd1);
    chk("t4_count", 64'(fifo_count), 64'd15);

    // Use the last credit, then issue without credit: sticky err and a drop.
    issue(16'h2000, 1'b1);
    step();
    issue_valid = 1'b0;
    chk("t5_ok_low", 64'(issue_ok), 64'd0);
    issue(16'h2010, 1'b0);
    step();
    issue_valid = 1'b0;
    chk("t5_err_set", 64'(err), 64'd1);
    for (int i = 0; i < 10; i++) step();
    chk("t5_err_sticky", 64'(err), 64'd1);
    chk("t5_count_full", 64'(fifo_count), 64'd16);

    // Capture into a full FIFO coinciding with a pop: both take effect.
    issue(16'h2020, 1'b1);
    step();
    issue_valid = 1'b0;
    for (int i = 0; i < PL - 1; i++) step();
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    chk("t5_full_pushpop", 64'(fifo_count), 64'd16);

    // Drain; the scoreboard checks order and that the dropped sample is absent.
    m_ready = 1'b1;
    budget = 0;
    while (fifo_count != 0 && budget < 40) begin
      step();
      budget++;
    end
    m_ready = 1'b0;
    chk("t5_drained", 64'(fifo_count), 64'd0);
    chk("t5_sb_empty", 64'(sbq.size()), 64'd0);
    chk("t5_err_held", 64'(err), 64'd1);

    // Reset with 3 buffered and 5 in flight.
    for (int c = 0; c < 11; c++) begin
      issue_valid = 1'b0;
      if (c < 8) issue(16'h3000 + 16'(c * 16), 1'b1);
      step();
    end
    issue_valid = 1'b0;
    chk("t6_buffered", 64'(fifo_count), 64'd3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    sbq.delete();
    chk("t6_valid", 64'(m_valid), 64'd0);
    chk("t6_count", 64'(fifo_count), 64'd0);
    chk("t6_err", 64'(err), 64'd0);
    chk("t6_ok", 64'(issue_ok), 64'd1);
    m_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      chk($sformatf("t6_quiet_c%0d", c), 64'(m_valid), 64'd0);
      step();
    end
    m_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
